// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse cursor tracker.
package mouse_pkg;
  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    APPLY   = 2'd3
  } mouse_state_t;

  // Status byte bit positions.
  localparam int BIT_L    = 0;
  localparam int BIT_R    = 1;
  localparam int BIT_SYNC = 3;
  localparam int BIT_XS   = 4;
  localparam int BIT_YS   = 5;
  localparam int BIT_XO   = 6;
  localparam int BIT_YO   = 7;

  localparam int ACCEL_THR = 16;
  localparam int POS_W     = 12;
  localparam int CALC_W    = 14;

  function automatic logic [8:0] mk_delta(input logic sign, input logic [7:0] lo);
    return {sign, lo};
  endfunction
endpackage

// File: rtl/vga_pkg.sv
// Screen timing constants shared by the video and cursor paths.
package vga_pkg;
  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
endpackage

// File: rtl/mouse_axis_update.sv
// One axis: signed delta applied to position and clamped to 0..limit; combinational, no backpressure.
// MOUSE_ACCEL_EN doubles deltas larger than ACCEL_THR in magnitude.
module mouse_axis_update
  import mouse_pkg::*;
(
  input  logic [POS_W-1:0] pos,
  input  logic [8:0]       delta,
  input  logic             ovf,
  input  logic             invert,
  input  logic [POS_W-1:0] limit,
  output logic [POS_W-1:0] new_pos
);

`ifdef MOUSE_ACCEL_EN
  localparam logic signed [CALC_W-1:0] THR = CALC_W'(ACCEL_THR);
  logic signed [CALC_W-1:0] d_abs;
`endif
  logic signed [CALC_W-1:0] d_ext;
  logic signed [CALC_W-1:0] d_eff;
  logic signed [CALC_W-1:0] pos_s;
  logic signed [CALC_W-1:0] lim_s;
  logic signed [CALC_W-1:0] sum;

  always_comb begin
    d_ext = ovf ? '0 : {{(CALC_W-9){delta[8]}}, delta};
`ifdef MOUSE_ACCEL_EN
    d_abs = d_ext[CALC_W-1] ? -d_ext : d_ext;
    d_eff = (d_abs > THR) ? (d_ext <<< 1) : d_ext;
`else
    d_eff = d_ext;
`endif
    pos_s = {2'b00, pos};
    lim_s = {2'b00, limit};
    sum   = invert ? (pos_s - d_eff) : (pos_s + d_eff);
    // Saturate rather than wrap at both screen edges.
    if (sum[CALC_W-1])
      new_pos = '0;
    else if (sum > lim_s)
      new_pos = limit;
    else
      new_pos = sum[POS_W-1:0];
  end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 packets into a saturated cursor position and buttons (MOUSE_ACCEL_EN: accel).
// Position updates 2 cycles after the last byte; no backpressure, every rx_valid byte is consumed.
module mouse_pos_tracker
  import vga_pkg::*, mouse_pkg::*;
#(
  parameter int H_RES          = H_ACTIVE,
  parameter int V_RES          = V_ACTIVE,
  parameter int INIT_X         = 512,
  parameter int INIT_Y         = 384,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [POS_W-1:0]  xpos,
  output logic [POS_W-1:0]  ypos,
  output logic              left,
  output logic              right,
  output logic              left_click,
  output logic              pos_valid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mouse_state_t state, state_nxt;
  logic [CNT_W-1:0] idle_cnt;
  logic [7:0]       status_q;
  logic [7:0]       xlo_q;
  logic [7:0]       ylo_q;
  logic             timeout;
  logic             take_status;
  logic             take_x;
  logic             take_y;
  logic             do_apply;
  logic             in_pkt;
  logic [POS_W-1:0] nx;
  logic [POS_W-1:0] ny;
  logic             unused_status;

  assign unused_status = ^{status_q[2], status_q[BIT_SYNC]};
  assign timeout = (idle_cnt == TO_LAST) && !rx_valid;

  always_ff @(posedge clk) begin
    if (rst)
      state <= WAIT_B0;
    else
      state <= state_nxt;
  end

  // APPLY shares WAIT_B0's rule so a byte landing during APPLY starts the next packet.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_B0, APPLY: state_nxt = (rx_valid && rx_data[BIT_SYNC]) ? WAIT_B1 : WAIT_B0;
      WAIT_B1:        state_nxt = rx_valid ? WAIT_B2 : (timeout ? WAIT_B0 : WAIT_B1);
      WAIT_B2:        state_nxt = rx_valid ? APPLY   : (timeout ? WAIT_B0 : WAIT_B2);
      default:        state_nxt = WAIT_B0;
    endcase
  end

  always_comb begin
    take_status = 1'b0;
    take_x      = 1'b0;
    take_y      = 1'b0;
    do_apply    = 1'b0;
    in_pkt      = 1'b0;
    case (state)
      WAIT_B0: take_status = rx_valid && rx_data[BIT_SYNC];
      WAIT_B1: begin
        take_x = rx_valid;
        in_pkt = 1'b1;
      end
      WAIT_B2: begin
        take_y = rx_valid;
        in_pkt = 1'b1;
      end
      APPLY: begin
        do_apply    = 1'b1;
        take_status = rx_valid && rx_data[BIT_SYNC];
      end
      default: ;
    endcase
  end

  mouse_axis_update u_axis_x (
    .pos     (xpos),
    .delta   (mk_delta(status_q[BIT_XS], xlo_q)),
    .ovf     (status_q[BIT_XO]),
    .invert  (1'b0),
    .limit   (POS_W'(H_RES - 1)),
    .new_pos (nx)
  );

  // PS/2 +Y is up while screen rows grow downward.
  mouse_axis_update u_axis_y (
    .pos     (ypos),
    .delta   (mk_delta(status_q[BIT_YS], ylo_q)),
    .ovf     (status_q[BIT_YO]),
    .invert  (1'b1),
    .limit   (POS_W'(V_RES - 1)),
    .new_pos (ny)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt   <= '0;
      status_q   <= '0;
      xlo_q      <= '0;
      ylo_q      <= '0;
      xpos       <= POS_W'(INIT_X);
      ypos       <= POS_W'(INIT_Y);
      left       <= 1'b0;
      right      <= 1'b0;
      left_click <= 1'b0;
      pos_valid  <= 1'b0;
    end else begin
      if (!in_pkt || rx_valid || timeout)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;

      if (take_status) status_q <= rx_data;
      if (take_x)      xlo_q    <= rx_data;
      if (take_y)      ylo_q    <= rx_data;

      pos_valid  <= do_apply;
      left_click <= do_apply && status_q[BIT_L] && !left;
      if (do_apply) begin
        xpos  <= nx;
        ypos  <= ny;
        left  <= status_q[BIT_L];
        right <= status_q[BIT_R];
      end
    end
  end

endmodule
